rs_multi_cdb: RTL
=================

RS_MULTI_CDB -- requirements
Module: rs_multi_cdb

Interface
REQ-001 RS_DEPTH, 16, number of entries; power of two, at least 2.
REQ-002 CDB_PORTS, 2, number of result-broadcast channels, at least 1.
REQ-003 ROB_POS_W, 4, ROB index width; TAG_W = ROB_POS_W+1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global enable; low freezes all state.
REQ-007 rollback  in  1  branch-mispredict flush.
REQ-008 issue  in  1  write one new entry this cycle.
REQ-009 issue_op  in  11  {funct7 bit, funct3, opcode}.
REQ-010 issue_rs1_val  in  32  operand 1 value, valid when tag MSB=0.
REQ-011 issue_rs1_tag  in  TAG_W  {pending, producer ROB pos}.
REQ-012 issue_rs2_val  in  32  operand 2 value.
REQ-013 issue_rs2_tag  in  TAG_W  operand 2 tag.
REQ-014 issue_imm  in  32  immediate.
REQ-015 issue_pc  in  32  instruction PC.
REQ-016 issue_rob_pos  in  ROB_POS_W  destination ROB slot.
REQ-017 rob_head  in  ROB_POS_W  oldest in-flight ROB slot, the age reference.
REQ-018 cdb_valid  in  CDB_PORTS  per-port broadcast strobe.
REQ-019 cdb_rob_pos  in  CDB_PORTS*ROB_POS_W  per-port producer slot, port 0 in LSBs.
REQ-020 cdb_val  in  CDB_PORTS*32  per-port result.
REQ-021 rs_count  out  clog2(RS_DEPTH+1)  occupied entries.
REQ-022 rs_nxt_full  out  1  high when rs_count >= RS_DEPTH-1.
REQ-023 alu_en  out  1  dispatch valid, held until accepted.
REQ-024 alu_ready  in  1  ALU accepts the payload this cycle.
REQ-025 alu_op  out  11  dispatched op fields.
REQ-026 alu_val1  out  32  operand 1.
REQ-027 alu_val2  out  32  operand 2.
REQ-028 alu_imm  out  32  immediate.
REQ-029 alu_pc  out  32  PC.
REQ-030 alu_rob_pos  out  ROB_POS_W  destination ROB slot.

Function
REQ-031 Issue SHALL write the lowest-index free entry and increment rs_count; issue while rs_count==RS_DEPTH SHALL be dropped and flagged by an assertion.
REQ-032 Each cycle, every busy entry's pending operand whose tag matches {1,cdb_rob_pos[p]} with cdb_valid[p]=1 SHALL take cdb_val[p] and clear its tag MSB; if several ports match, the lowest port wins.
REQ-033 Issue SHALL snoop the CDB in the same cycle, so an operand broadcast in the issue cycle is captured as ready.
REQ-034 An entry is ready when busy and both tag MSBs are 0; readiness is evaluated only from registered state, so a woken entry becomes selectable one cycle after wakeup.
REQ-035 Selection SHALL pick the ready entry with the minimum (rob_pos - rob_head) mod 2^ROB_POS_W, i.e. oldest first across wrap-around.
REQ-036 Dispatch fires when a ready entry exists and (!alu_en || alu_ready): output registers load the selected entry, the entry frees, alu_en=1.
REQ-037 When alu_en && alu_ready and nothing is ready, alu_en SHALL drop to 0; while alu_en && !alu_ready, the payload SHALL stay stable.
REQ-038 Minimum latency: with ready operands sampled at issue edge k, alu_en=1 after edge k+1.
REQ-039 A slot freed at an edge SHALL NOT be reused by an issue on that edge; rs_count += issue - dispatch.
REQ-040 Rollback at an active edge SHALL clear all entries, rs_count and alu_en; issue and CDB in that cycle are ignored.
REQ-041 Priority SHALL be rst > !rdy > rollback > normal; rdy low SHALL drop issue and CDB inputs.

Reset
REQ-042 rst SHALL take effect regardless of rdy, clearing busy[*]=0, alu_en=0, rs_count=0 and all alu_* payload to 0.

Structure
REQ-043 RS_DEPTH, ROB_POS_W, TAG_W, op-field widths and the RS_NPOS sentinel SHALL live in the shared define header.
REQ-044 The oldest-ready picker SHALL be a parametrised combinational sub-module rs_age_select.

Verification
REQ-045 DEPTH=4, rob_head=5, issue ready entries with rob_pos 7,5,6, alu_ready=1 -> alu_rob_pos 5,6,7 on consecutive cycles.
REQ-046 rob_head=14, ready entries with rob_pos 1 and 15 -> 15 dispatched first, 1 next.
REQ-047 Issue rs1_tag={1,3} while cdb_valid[1]=1, cdb_rob_pos[1]=3, cdb_val[1]=0xDEADBEEF -> alu_val1=0xDEADBEEF, alu_en after edge k+1.
REQ-048 alu_en=1, alu_ready=0 for 3 cycles with another entry ready -> payload stable, rs_count unchanged; alu_ready=1 -> next entry loaded.
REQ-049 DEPTH=4, fill 3 entries -> rs_nxt_full=1; rollback with concurrent CDB -> rs_count=0, alu_en=0, no capture.
REQ-050 rdy=0 for 5 cycles with issue and CDB toggling -> no state change; rst with rdy=0 -> full reset.

Source files
------------

// File: rtl/rs_multi_cdb_pkg.sv
// Shared sizing constants for the multi-CDB reservation station.
package rs_multi_cdb_pkg;

  localparam int unsigned RS_DEPTH  = 16;
  localparam int unsigned CDB_PORTS = 2;
  localparam int unsigned ROB_POS_W = 4;
  localparam int unsigned TAG_W     = ROB_POS_W + 1;

  localparam int unsigned FUNCT7_BIT_W = 1;
  localparam int unsigned FUNCT3_W     = 3;
  localparam int unsigned OPCODE_W     = 7;
  localparam int unsigned OP_W         = FUNCT7_BIT_W + FUNCT3_W + OPCODE_W;

  // Index reported by the picker when no entry is ready (truncated to the index width).
  localparam int unsigned RS_NPOS = 32'hFFFF_FFFF;

endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: minimum (rob_pos - rob_head) mod 2^RobPosW, lowest index on ties.
module rs_age_select
  import rs_multi_cdb_pkg::*;
#(
  parameter int unsigned Depth   = RS_DEPTH,
  parameter int unsigned RobPosW = ROB_POS_W,
  localparam int unsigned IdxW   = $clog2(Depth)
) (
  input  logic [Depth-1:0]         ready_i,
  input  logic [Depth*RobPosW-1:0] rob_pos_i,
  input  logic [RobPosW-1:0]       rob_head_i,
  output logic                     valid_o,
  output logic [IdxW-1:0]          idx_o
);

  logic [RobPosW-1:0] best_age;
  logic [RobPosW-1:0] age;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = IdxW'(RS_NPOS);
    best_age = '1;
    age      = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      age = rob_pos_i[i*RobPosW +: RobPosW] - rob_head_i;
      if (ready_i[i] && (!valid_o || age < best_age)) begin
        valid_o  = 1'b1;
        best_age = age;
        idx_o    = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// ALU reservation station with multi-port CDB wakeup and oldest-first dispatch.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int unsigned RsDepth  = RS_DEPTH,
  parameter int unsigned CdbPorts = CDB_PORTS,
  parameter int unsigned RobPosW  = ROB_POS_W,
  localparam int unsigned TagW    = RobPosW + 1,
  localparam int unsigned CntW    = $clog2(RsDepth + 1),
  localparam int unsigned IdxW    = $clog2(RsDepth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rdy_i,
  input  logic                     rollback_i,
  input  logic                     issue_i,
  input  logic [OP_W-1:0]          issue_op_i,
  input  logic [31:0]              issue_rs1_val_i,
  input  logic [TagW-1:0]          issue_rs1_tag_i,
  input  logic [31:0]              issue_rs2_val_i,
  input  logic [TagW-1:0]          issue_rs2_tag_i,
  input  logic [31:0]              issue_imm_i,
  input  logic [31:0]              issue_pc_i,
  input  logic [RobPosW-1:0]       issue_rob_pos_i,
  input  logic [RobPosW-1:0]       rob_head_i,
  input  logic [CdbPorts-1:0]      cdb_valid_i,
  input  logic [CdbPorts*RobPosW-1:0] cdb_rob_pos_i,
  input  logic [CdbPorts*32-1:0]   cdb_val_i,
  output logic [CntW-1:0]          rs_count_o,
  output logic                     rs_nxt_full_o,
  output logic                     alu_en_o,
  input  logic                     alu_ready_i,
  output logic [OP_W-1:0]          alu_op_o,
  output logic [31:0]              alu_val1_o,
  output logic [31:0]              alu_val2_o,
  output logic [31:0]              alu_imm_o,
  output logic [31:0]              alu_pc_o,
  output logic [RobPosW-1:0]       alu_rob_pos_o
);

  logic [RsDepth-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q   [RsDepth];
  logic [OP_W-1:0]    op_d   [RsDepth];
  logic [31:0]        val1_q [RsDepth];
  logic [31:0]        val1_d [RsDepth];
  logic [TagW-1:0]    tag1_q [RsDepth];
  logic [TagW-1:0]    tag1_d [RsDepth];
  logic [31:0]        val2_q [RsDepth];
  logic [31:0]        val2_d [RsDepth];
  logic [TagW-1:0]    tag2_q [RsDepth];
  logic [TagW-1:0]    tag2_d [RsDepth];
  logic [31:0]        imm_q  [RsDepth];
  logic [31:0]        imm_d  [RsDepth];
  logic [31:0]        pc_q   [RsDepth];
  logic [31:0]        pc_d   [RsDepth];
  logic [RobPosW-1:0] pos_q  [RsDepth];
  logic [RobPosW-1:0] pos_d  [RsDepth];

  logic [CntW-1:0]    count_q, count_d;
  logic               alu_en_q, alu_en_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [31:0]        alu_val1_q, alu_val1_d, alu_val2_q, alu_val2_d;
  logic [31:0]        alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
  logic [RobPosW-1:0] alu_pos_q, alu_pos_d;

  logic [RsDepth-1:0]         ready;
  logic [RsDepth*RobPosW-1:0] pos_flat;
  logic                       sel_valid, fire, free_ok, issue_ok;
  logic [IdxW-1:0]            sel_idx, free_idx;

  // Lowest matching port wins because it is applied last.
  function automatic logic [TagW+31:0] snoop(input logic [TagW-1:0] tag, input logic [31:0] val,
                                             input logic [CdbPorts-1:0] cv,
                                             input logic [CdbPorts*RobPosW-1:0] cp,
                                             input logic [CdbPorts*32-1:0] cd);
    logic [TagW+31:0] res;
    res = {tag, val};
    for (int p = int'(CdbPorts) - 1; p >= 0; p--) begin
      if (tag[TagW-1] && cv[p] && cp[p*RobPosW +: RobPosW] == tag[RobPosW-1:0]) begin
        res = {1'b0, tag[RobPosW-1:0], cd[p*32 +: 32]};
      end
    end
    return res;
  endfunction

  always_comb begin
    ready    = '0;
    pos_flat = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = int'(RsDepth) - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] && !tag1_q[i][TagW-1] && !tag2_q[i][TagW-1];
      pos_flat[i*RobPosW +: RobPosW] = pos_q[i];
      if (!busy_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  rs_age_select #(
    .Depth  (RsDepth),
    .RobPosW(RobPosW)
  ) u_age_select (
    .ready_i   (ready),
    .rob_pos_i (pos_flat),
    .rob_head_i(rob_head_i),
    .valid_o   (sel_valid),
    .idx_o     (sel_idx)
  );

  assign fire     = sel_valid && (!alu_en_q || alu_ready_i);
  assign issue_ok = issue_i && free_ok;

  always_comb begin
    busy_d     = busy_q;
    op_d       = op_q;
    val1_d     = val1_q;
    tag1_d     = tag1_q;
    val2_d     = val2_q;
    tag2_d     = tag2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    pos_d      = pos_q;
    count_d    = count_q;
    alu_en_d   = alu_en_q;
    alu_op_d   = alu_op_q;
    alu_val1_d = alu_val1_q;
    alu_val2_d = alu_val2_q;
    alu_imm_d  = alu_imm_q;
    alu_pc_d   = alu_pc_q;
    alu_pos_d  = alu_pos_q;

    for (int i = 0; i < int'(RsDepth); i++) begin
      if (busy_q[i]) begin
        {tag1_d[i], val1_d[i]} = snoop(tag1_q[i], val1_q[i], cdb_valid_i, cdb_rob_pos_i,
                                       cdb_val_i);
        {tag2_d[i], val2_d[i]} = snoop(tag2_q[i], val2_q[i], cdb_valid_i, cdb_rob_pos_i,
                                       cdb_val_i);
      end
    end

    if (fire) begin
      busy_d[sel_idx] = 1'b0;
      alu_en_d   = 1'b1;
      alu_op_d   = op_q[sel_idx];
      alu_val1_d = val1_q[sel_idx];
      alu_val2_d = val2_q[sel_idx];
      alu_imm_d  = imm_q[sel_idx];
      alu_pc_d   = pc_q[sel_idx];
      alu_pos_d  = pos_q[sel_idx];
    end else if (alu_en_q && alu_ready_i) begin
      alu_en_d = 1'b0;
    end

    // free_idx comes from registered busy, so a slot freed this edge is not reused.
    if (issue_ok) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = issue_op_i;
      imm_d[free_idx]  = issue_imm_i;
      pc_d[free_idx]   = issue_pc_i;
      pos_d[free_idx]  = issue_rob_pos_i;
      {tag1_d[free_idx], val1_d[free_idx]} = snoop(issue_rs1_tag_i, issue_rs1_val_i,
                                                   cdb_valid_i, cdb_rob_pos_i, cdb_val_i);
      {tag2_d[free_idx], val2_d[free_idx]} = snoop(issue_rs2_tag_i, issue_rs2_val_i,
                                                   cdb_valid_i, cdb_rob_pos_i, cdb_val_i);
    end

    count_d = count_q + CntW'(issue_ok) - CntW'(fire);

    if (rollback_i) begin
      busy_d   = '0;
      count_d  = '0;
      alu_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      count_q    <= '0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      alu_val1_q <= '0;
      alu_val2_q <= '0;
      alu_imm_q  <= '0;
      alu_pc_q   <= '0;
      alu_pos_q  <= '0;
    end else if (rdy_i) begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      alu_val1_q <= alu_val1_d;
      alu_val2_q <= alu_val2_d;
      alu_imm_q  <= alu_imm_d;
      alu_pc_q   <= alu_pc_d;
      alu_pos_q  <= alu_pos_d;
    end
  end

  // Entry payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (rdy_i) begin
      op_q   <= op_d;
      val1_q <= val1_d;
      tag1_q <= tag1_d;
      val2_q <= val2_d;
      tag2_q <= tag2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      pos_q  <= pos_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && rdy_i && !rollback_i && issue_i) begin
      assert (count_q != CntW'(RsDepth)) else $error("rs_multi_cdb: issue while full dropped");
    end
  end
`endif

  assign rs_count_o    = count_q;
  assign rs_nxt_full_o = (count_q >= CntW'(RsDepth - 1));
  assign alu_en_o      = alu_en_q;
  assign alu_op_o      = alu_op_q;
  assign alu_val1_o    = alu_val1_q;
  assign alu_val2_o    = alu_val2_q;
  assign alu_imm_o     = alu_imm_q;
  assign alu_pc_o      = alu_pc_q;
  assign alu_rob_pos_o = alu_pos_q;

endmodule
